// File: rtl/pim_arb_pkg.sv
// Shared types and default sizing for the PIM arbiter.
package pim_arb_pkg;

  localparam int DEF_INSTR_W = 45;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pim_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr (mod NREQ) wins.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   index,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + 32'(k)) % 32'(NREQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        index       = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/pim_arbiter.sv
// Round-robin arbiter/sequencer sharing one PIM among NREQ requesters.
// Optional watchdog abort compiled in with `define PIM_ARB_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | arbitrate; winner latched, gnt + operation_enable issued on exit
// ISSUE   | operation_enable high for this single cycle
// WAIT_LO | wait for the PIM to drop ready (operation accepted)
// WAIT_HI | wait for ready to return; capture data_out, pulse done
module pim_arbiter
  import pim_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*INSTR_W-1:0] instr,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    err,
  output logic [INSTR_W-1:0]      pim_instruction,
  output logic                    pim_operation_enable,
  input  logic                    pim_ready,
  input  logic [DATA_W-1:0]       pim_data_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("pim_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("pim_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_e          state, state_nxt;
  logic [PW-1:0]       ptr, ptr_nxt;
  logic [PW-1:0]       owner, owner_nxt;
  logic [NREQ-1:0]     gnt_nxt, done_nxt;
  logic [INSTR_W-1:0]  instr_nxt;
  logic [DATA_W-1:0]   rsp_nxt;
  logic                op_en_nxt;

  logic [NREQ-1:0]     win_onehot;
  logic [PW-1:0]       win_idx;
  logic                win_any;

`ifdef PIM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic          err_nxt;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (win_onehot),
    .index  (win_idx),
    .any    (win_any)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    gnt_nxt   = '0;
    done_nxt  = '0;
    instr_nxt = pim_instruction;
    rsp_nxt   = rsp_data;
    op_en_nxt = 1'b0;
`ifdef PIM_ARB_WATCHDOG_EN
    err_nxt    = 1'b0;
    wd_cnt_nxt = (state == IDLE) ? '0 : wd_cnt + CW'(1);
`endif

    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = ISSUE;
          owner_nxt = win_idx;
          gnt_nxt   = win_onehot;
          op_en_nxt = 1'b1;
          instr_nxt = instr[win_idx*INSTR_W +: INSTR_W];
          ptr_nxt   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
        end
      end
      ISSUE: begin
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!pim_ready) state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (pim_ready) begin
          state_nxt = IDLE;
          done_nxt  = NREQ'(1) << owner;
          rsp_nxt   = pim_data_out;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef PIM_ARB_WATCHDOG_EN
    // Counter is 0 in ISSUE, so TIMEOUT-1 lands the done exactly TIMEOUT cycles after ISSUE.
    if ((state == WAIT_LO || state == WAIT_HI) && wd_cnt == CW'(TIMEOUT-1)
        && !(state == WAIT_HI && pim_ready)) begin
      state_nxt = IDLE;
      done_nxt  = NREQ'(1) << owner;
      rsp_nxt   = '0;
      err_nxt   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      ptr                  <= '0;
      owner                <= '0;
      gnt                  <= '0;
      done                 <= '0;
      rsp_data             <= '0;
      pim_instruction      <= '0;
      pim_operation_enable <= 1'b0;
    end else begin
      state                <= state_nxt;
      ptr                  <= ptr_nxt;
      owner                <= owner_nxt;
      gnt                  <= gnt_nxt;
      done                 <= done_nxt;
      rsp_data             <= rsp_nxt;
      pim_instruction      <= instr_nxt;
      pim_operation_enable <= op_en_nxt;
    end
  end

`ifdef PIM_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      err    <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pim_arbiter.sv
// Scoreboard bench for pim_arbiter: expected grants/completions queued at stimulus time.
module tb_pim_arbiter;

  localparam int NREQ    = 4;
  localparam int INSTR_W = 45;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*INSTR_W-1:0] instr;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         done;
  logic [DATA_W-1:0]       rsp_data;
  logic                    err;
  logic [INSTR_W-1:0]      pim_instruction;
  logic                    pim_operation_enable;
  logic                    pim_ready;
  logic [DATA_W-1:0]       pim_data_out;

  pim_arbiter #(
    .NREQ    (NREQ),
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (req),
    .instr                (instr),
    .gnt                  (gnt),
    .done                 (done),
    .rsp_data             (rsp_data),
    .err                  (err),
    .pim_instruction      (pim_instruction),
    .pim_operation_enable (pim_operation_enable),
    .pim_ready            (pim_ready),
    .pim_data_out         (pim_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; logic [INSTR_W-1:0] ins; } gexp_t;
  typedef struct { int idx; logic [DATA_W-1:0] data; logic err; } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int n_vec = 0;
  int n_miscmp = 0;

  // PIM model knobs
  int               pim_lo    = 3;
  bit               pim_stuck = 1'b0;
  logic [DATA_W-1:0] pim_base = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [INSTR_W-1:0] mk_instr(input int i);
    logic [INSTR_W-1:0] v;
    v = {13'h0A5, 32'h1000_0000 * 32'(i + 1) + 32'h0000_0C3C};
    return v;
  endfunction

  task automatic push_op(input int i, input logic [INSTR_W-1:0] ins, input bit with_done);
    gexp_t g;
    dexp_t d;
    g.idx = i; g.ins = ins;
    gq.push_back(g);
    if (with_done) begin
      d.idx = i; d.data = pim_base ^ ins[31:0]; d.err = 1'b0;
      dq.push_back(d);
    end
  endtask

  // PIM behavioural model: ready low for pim_lo cycles after an enable, then result.
  initial begin
    pim_ready    = 1'b1;
    pim_data_out = '0;
    forever begin
      @(negedge clk);
      if (pim_operation_enable && !pim_stuck) begin
        pim_ready = 1'b0;
        repeat (pim_lo) @(negedge clk);
        pim_data_out = pim_base ^ pim_instruction[31:0];
        pim_ready    = 1'b1;
      end
    end
  end

  // Output monitor: pops the scoreboard on every gnt/done pulse.
  initial begin
    gexp_t g;
    dexp_t d;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (gnt != '0 || pim_operation_enable) begin
          chk("issue_with_gnt", 64'(pim_operation_enable), 64'(gnt != '0));
          if (gnt != '0) begin
            if (gq.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'(0));
            else begin
              g = gq.pop_front();
              chk("gnt", 64'(gnt), 64'(1) << g.idx);
              chk("pim_instr", 64'(pim_instruction), 64'(g.ins));
            end
          end
        end
        if (done != '0) begin
          if (dq.size() == 0) chk("done_unexpected", 64'(done), 64'(0));
          else begin
            d = dq.pop_front();
            chk("done", 64'(done), 64'(1) << d.idx);
            chk("rsp_data", 64'(rsp_data), 64'(d.data));
            chk("err", 64'(err), 64'(d.err));
          end
        end
      end
    end
  end

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        idx = oh2idx(gnt);
        return;
      end
    end
    chk("gnt_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (done != '0) begin
        cycles = i;
        return;
      end
    end
    chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   64'(gnt), 64'(0));
    chk({tag, "_done"},  64'(done), 64'(0));
    chk({tag, "_err"},   64'(err), 64'(0));
    chk({tag, "_rsp"},   64'(rsp_data), 64'(0));
    chk({tag, "_instr"}, 64'(pim_instruction), 64'(0));
    chk({tag, "_open"},  64'(pim_operation_enable), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int idx;
    int cyc;
    int seen;
    logic [INSTR_W-1:0] ins;

    rst   = 1'b0;
    req   = '0;
    instr = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // single request from requester 2
    ins = 45'h1_2345_6789;
    pim_lo   = 3;
    pim_base = 32'hDEADBEEF ^ ins[31:0];
    push_op(2, ins, 1'b1);
    instr[2*INSTR_W +: INSTR_W] = ins;
    req = 4'b0100;
    wait_gnt(idx);
    req = '0;
    wait_done(50, cyc);
    chk("single_rsp", 64'(rsp_data), 64'h0000_0000_DEAD_BEEF);

    // contention with all four requesting from reset
    @(negedge clk);
    rst = 1'b0;
    pim_lo   = 2;
    pim_base = 32'h5A5A_0F0F;
    for (int i = 0; i < NREQ; i++) instr[i*INSTR_W +: INSTR_W] = mk_instr(i);
    req = 4'b1111;
    push_op(0, mk_instr(0), 1'b1);
    push_op(1, mk_instr(1), 1'b1);
    push_op(2, mk_instr(2), 1'b1);
    push_op(3, mk_instr(3), 1'b1);
    push_op(0, mk_instr(0), 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(idx);
      if (g == 4) req = '0;
    end
    wait_done(50, cyc);

    // late arrival: 3 arrives while 1 is in WAIT_HI, 0 already pending
    do_reset();
    pim_lo   = 4;
    pim_base = 32'h0123_4567;
    for (int i = 0; i < NREQ; i++) instr[i*INSTR_W +: INSTR_W] = mk_instr(i + 4);
    push_op(1, mk_instr(5), 1'b1);
    push_op(3, mk_instr(7), 1'b1);
    push_op(0, mk_instr(4), 1'b1);
    req = 4'b0010;
    wait_gnt(idx);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    req = 4'b1001;
    wait_gnt(idx);
    req[3] = 1'b0;
    wait_gnt(idx);
    req[0] = 1'b0;
    wait_done(50, cyc);

    // reset while in WAIT_HI: operation dropped, ptr back to 0
    @(negedge clk);
    pim_lo   = 6;
    pim_base = 32'hCAFE_0000;
    push_op(2, mk_instr(6), 1'b0);
    req = 4'b0100;
    wait_gnt(idx);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    repeat (8) @(negedge clk);
    chk("midop_no_done", 64'(done), 64'(0));
    pim_lo = 2;
    push_op(0, mk_instr(4), 1'b1);
    push_op(3, mk_instr(7), 1'b1);
    req = 4'b1001;
    rst = 1'b1;
    wait_gnt(idx);
    req[0] = 1'b0;
    wait_gnt(idx);
    req[3] = 1'b0;
    wait_done(50, cyc);

    // stuck-ready PIM
    do_reset();
    pim_stuck = 1'b1;
    push_op(1, mk_instr(5), 1'b0);
`ifdef PIM_ARB_WATCHDOG_EN
    begin
      dexp_t d;
      d.idx = 1; d.data = '0; d.err = 1'b1;
      dq.push_back(d);
    end
`endif
    req = 4'b0010;
    wait_gnt(idx);
    req = '0;
`ifdef PIM_ARB_WATCHDOG_EN
    wait_done(100, cyc);
    chk("wd_latency", 64'(cyc), 64'(TIMEOUT));
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    chk("no_wd_no_done", 64'(seen), 64'(0));
`endif
    do_reset();
    pim_stuck = 1'b0;
    repeat (3) @(negedge clk);

    chk("gq_drained", 64'(gq.size()), 64'(0));
    chk("dq_drained", 64'(dq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/pim_arbiter.md
# pim_arbiter

Round-robin arbiter and sequencer that shares one PIM instance among NREQ requesters. Each requester presents an encoded 45-bit PIM instruction with a request line. The arbiter grants one requester, issues the instruction to the PIM with a single-cycle operation_enable pulse, and waits for PIM completion. It then returns the PIM data_out word to the owning requester with a one-cycle done pulse. It sits between the requester fabric and the PIM top level and owns every PIM control input.

## Interface
- NREQ, 4, number of requesters (2..8)
- INSTR_W, 45, PIM instruction width
- DATA_W, 32, PIM data width
- TIMEOUT, 1024, watchdog limit in cycles (used only with the watchdog compiled in)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- instr  in  NREQ*INSTR_W  per-requester instruction; slot i at [i*INSTR_W +: INSTR_W]
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- done  out  NREQ  one-hot, one-cycle completion pulse
- rsp_data  out  DATA_W  result word; valid in the done cycle, held until the next completion
- err  out  1  with done: operation aborted by the watchdog (tied 0 when the watchdog is compiled out)
- pim_instruction  out  INSTR_W  to PIM instruction
- pim_operation_enable  out  1  to PIM operation_enable
- pim_ready  in  1  from PIM ready
- pim_data_out  in  DATA_W  from PIM data_out

## Operation
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI.
- IDLE, any req high:
  - Pick the winner with round-robin order, starting at pointer ptr.
  - Latch instr[winner] into pim_instruction and record the owner.
  - Pulse gnt[owner]. Go to ISSUE.
  - Set ptr to (owner+1) mod NREQ.
- ISSUE: pim_operation_enable=1 for exactly this one cycle. Go to WAIT_LO.
- WAIT_LO: wait for pim_ready=0, then go to WAIT_HI.
- WAIT_HI: wait for pim_ready=1, then:
  - Capture pim_data_out into rsp_data.
  - Pulse done[owner]. Go to IDLE.
- pim_instruction stays stable from ISSUE until the return to IDLE.
- Requester rules:
  - Holds req and instr stable until it sees gnt.
  - May drop req, or change instr, in the cycle after gnt.
  - A req still high after done counts as a new request.
- A req that falls before being granted is simply not served. No error is raised.
- Only one operation is ever outstanding. Requests arriving during an operation wait in IDLE arbitration.

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - gnt=0, done=0, err=0
  - rsp_data=0, pim_instruction=0, pim_operation_enable=0
- Reset mid-operation drops the operation silently: no done pulse. The PIM receives its own reset separately.
- Latency:
  - gnt registered one cycle after req is sampled in IDLE.
  - pim_operation_enable in the same cycle as gnt (ISSUE).
  - done one cycle after pim_ready is sampled high in WAIT_HI.
- Minimum request-to-done latency is 4 cycles with an instant PIM. The arbiter returns to IDLE in the done cycle, so the next gnt can follow one cycle after done.
- Simultaneous requests: the lowest index at or after ptr (mod NREQ) wins. Every continuously requesting requester is served within NREQ grants.
- Wrap-around: owner NREQ-1 sets ptr=0.

## Configuration
- PIM_ARB_WATCHDOG_EN defined:
  - A counter clears on ISSUE and counts in WAIT_LO/WAIT_HI.
  - At TIMEOUT-1 it forces IDLE, pulses done[owner] with err=1, and sets rsp_data=0.
  - A real completion in the same cycle wins: err=0.
- Undefined: no counter, err tied 0, and the arbiter waits for the PIM indefinitely.

## Structure
- Package pim_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_LO, WAIT_HI);
  - default widths (INSTR_W=45, DATA_W=32);
  - the default TIMEOUT.
- Sub-module rr_picker: combinational NREQ-wide round-robin select. Inputs: req, ptr. Outputs: one-hot winner, encoded index, any.

## Test plan
- Single request: req[2]=1 with instr=45'h1_2345_6789; PIM ready low 3 cycles then high, pim_data_out=32'hDEADBEEF. Expect gnt[2] and pim_operation_enable in the same cycle, then done[2] with rsp_data=32'hDEADBEEF, err=0.
- Contention: req=4'b1111 held from reset. Expect grant order 0,1,2,3,0, with ptr=0 after the grant to requester 3.
- Late arrival: req[3] asserted while requester 1 is in WAIT_HI, req[0] also pending. Expect the next grant to go to 3 (ptr=2), then 0.
- Reset mid-operation: rst=0 during WAIT_HI. Expect all outputs 0, no done pulse, and the next grant to go to requester 0.
- Watchdog (PIM_ARB_WATCHDOG_EN, TIMEOUT=16): pim_ready stuck 1. Expect done[owner] with err=1 and rsp_data=0 exactly 16 cycles after ISSUE. Without the macro, expect no done within 100 cycles.
